// File: rtl/hsi_m_rx_frame_buf.sv
//==============================================================================
// Module  : hsi_m_rx_frame_buf
// Brief   : Receive frame buffer with commit/rollback byte store, a frame-length
//           queue and a byte-wise read port.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module hsi_m_rx_frame_buf #(
    parameter int AW = 6,
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    q,
    input  logic          q_rdy,
    input  logic          rx_frame_end,
    input  logic [5:0]    rx_errs,
    output logic          frame_avail,
    output logic [AW:0]   frame_len,
    input  logic          rd_req,
    output logic [7:0]    rd_d,
    output logic          rd_vld,
    output logic          rd_last,
    output logic          drop,
    output logic [7:0]    drop_cnt
);

    localparam int c_DEPTH  = 1 << AW;
    localparam int c_QDEPTH = 1 << LW;

    logic [7:0]  r_mem [c_DEPTH];
    logic [AW:0] r_lq  [c_QDEPTH];

    logic [AW:0] r_wp;
    logic [AW:0] r_cp;
    logic [AW:0] r_rp;
    logic [AW:0] r_cur_len;
    logic [AW:0] r_rd_cnt;
    logic        r_poison;
    logic [LW:0] r_lq_wp;
    logic [LW:0] r_lq_rp;

    logic        w_full;
    logic        w_wr;
    logic [AW:0] w_wp_nxt;
    logic [AW:0] w_len_eff;
    logic        w_poison_eff;
    logic        w_lq_full;
    logic        w_lq_empty;
    logic        w_commit;
    logic        w_drop_set;
    logic        w_rd;
    logic        w_rd_end;
    logic [AW:0] w_head;

    assign w_full       = (r_wp - r_rp) == {1'b1, {AW{1'b0}}};
    assign w_wr         = q_rdy && !w_full && !r_poison;
    assign w_wp_nxt     = r_wp + {{AW{1'b0}}, w_wr};
    // A byte arriving together with rx_frame_end belongs to the ending frame.
    assign w_len_eff    = r_cur_len + {{AW{1'b0}}, w_wr};
    assign w_poison_eff = r_poison || (q_rdy && w_full);

    assign w_lq_empty   = (r_lq_wp == r_lq_rp);
    assign w_lq_full    = (r_lq_wp - r_lq_rp) == {1'b1, {LW{1'b0}}};
    assign w_head       = r_lq[r_lq_rp[LW-1:0]];

    assign w_commit     = rx_frame_end && rx_errs[0] && !w_poison_eff &&
                          (w_len_eff != '0) && !w_lq_full;
    // An empty but otherwise good frame is discarded silently.
    assign w_drop_set   = rx_frame_end && !w_commit &&
                          !((w_len_eff == '0) && rx_errs[0] && !w_poison_eff);

    assign w_rd         = rd_req && !w_lq_empty;
    assign w_rd_end     = w_rd && ((r_rd_cnt + 1'b1) == w_head);

    assign frame_avail  = !w_lq_empty;
    assign frame_len    = w_lq_empty ? '0 : w_head;

    // Storage arrays carry no reset; pointers define their valid contents.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= q;
        end
        if (w_commit) begin
            r_lq[r_lq_wp[LW-1:0]] <= w_len_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp      <= '0;
            r_cp      <= '0;
            r_rp      <= '0;
            r_cur_len <= '0;
            r_rd_cnt  <= '0;
            r_poison  <= 1'b0;
            r_lq_wp   <= '0;
            r_lq_rp   <= '0;
            rd_d      <= 8'h00;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            drop      <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            if (rx_frame_end) begin
                r_cur_len <= '0;
                r_poison  <= 1'b0;
                if (w_commit) begin
                    r_wp    <= w_wp_nxt;
                    r_cp    <= w_wp_nxt;
                    r_lq_wp <= r_lq_wp + 1'b1;
                end else begin
                    r_wp <= r_cp;
                end
            end else begin
                r_wp <= w_wp_nxt;
                if (w_wr) begin
                    r_cur_len <= r_cur_len + 1'b1;
                end
                if (q_rdy && w_full) begin
                    r_poison <= 1'b1;
                end
            end

            drop <= w_drop_set;
            if (w_drop_set && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            rd_vld  <= w_rd;
            rd_last <= w_rd_end;
            if (w_rd) begin
                rd_d <= r_mem[r_rp[AW-1:0]];
                r_rp <= r_rp + 1'b1;
                if (w_rd_end) begin
                    r_rd_cnt <= '0;
                    r_lq_rp  <= r_lq_rp + 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/hsi_m_rx_frame_buf.md
HSI_M_RX_FRAME_BUF -- requirements
Module: hsi_m_rx_frame_buf

Interface
REQ-001 Parameter: AW, default 6, byte-store address width; store depth is 2^AW bytes.
REQ-002 Parameter: LW, default 2, length-queue address width; queue depth is 2^LW frames.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  in  1  system clock; all logic is rising-edge.
REQ-005 Port: rst  in  1  asynchronous reset, active-high.
REQ-006 Port: q  in  8  received byte from the master receive controller.
REQ-007 Port: q_rdy  in  1  one-cycle strobe; q is valid this cycle.
REQ-008 Port: rx_frame_end  in  1  one-cycle strobe marking the end of the current received frame.
REQ-009 Port: rx_errs  in  6  frame status, sampled at rx_frame_end; bit0=1 means frame good, bits5:1 are error flags.
REQ-010 Port: frame_avail  out  1  at least one committed frame is stored.
REQ-011 Port: frame_len  out  AW+1  byte count of the oldest committed frame; valid while frame_avail=1.
REQ-012 Port: rd_req  in  1  one-cycle request for the next byte of the oldest committed frame.
REQ-013 Port: rd_d  out  8  read byte.
REQ-014 Port: rd_vld  out  1  one-cycle strobe; rd_d is valid.
REQ-015 Port: rd_last  out  1  asserted together with rd_vld on the final byte of a frame.
REQ-016 Port: drop  out  1  one-cycle strobe; the current incoming frame was discarded.
REQ-017 Port: drop_cnt  out  8  saturating count of discarded frames.

Function
REQ-018 Byte store: dual-pointer RAM of 2^AW bytes.
  - Write pointer wp, commit pointer cp, read pointer rp, each AW+1 bits with a wrap bit.
  - Store full when wp-rp = 2^AW; empty when cp = rp.
REQ-019 On q_rdy with the store not full and the frame not already poisoned: write q at wp, wp+1, cur_len+1.
REQ-020 On q_rdy with the store full: set poison; discard the byte.
REQ-021 On rx_frame_end, the frame SHALL commit only when all of the following hold:
  - rx_errs[0]=1;
  - not poisoned;
  - cur_len>0;
  - the length queue is not full.
  On commit: cp<=wp and push cur_len.
REQ-022 On rx_frame_end with any commit condition failing: wp<=cp (rollback) and clear poison.
  - drop pulses one cycle later, except when cur_len=0 and the frame is good (silent discard).
  - drop_cnt increments on every drop pulse and saturates at 255.
REQ-023 cur_len SHALL clear on every rx_frame_end.
REQ-024 When q_rdy and rx_frame_end occur in the same cycle, the byte SHALL be counted in the frame being ended and is subject to the same commit/rollback.
REQ-025 Length queue: FIFO of 2^LW entries of AW+1 bits.
  - frame_avail = queue not empty.
  - frame_len = head entry.
REQ-026 Read handshake:
  - rd_req with frame_avail=1 reads RAM[rp]; rd_vld and rd_d appear in the next cycle (latency 1); rp+1; rd_cnt+1.
  - rd_req with frame_avail=0 SHALL be ignored; no rd_vld.
REQ-027 When rd_cnt reaches frame_len:
  - rd_last is asserted with that rd_vld;
  - the length queue pops in the same cycle the last read is accepted;
  - rd_cnt clears.
  - frame_avail reflects the next entry from the following cycle.
REQ-028 Simultaneous commit and pop in one cycle SHALL both take effect; queue occupancy is unchanged.
REQ-029 Reads never pass cp; reading of committed data proceeds concurrently with reception of a new frame.
REQ-030 A frame of exactly 2^AW bytes SHALL commit when the store was empty; byte 2^AW+1 poisons it.

Reset
REQ-031 On rst, asynchronously:
  - wp, cp, rp, cur_len, rd_cnt and poison are cleared;
  - the length queue is emptied;
  - drop_cnt is cleared.
  Outputs reset to: frame_avail=0, frame_len=0, rd_d=0, rd_vld=0, rd_last=0, drop=0, drop_cnt=0.
REQ-032 Reset mid-frame or mid-read SHALL discard all stored data with no drop pulse; the first q_rdy after reset release starts a new frame.

Verification
REQ-033 Three bytes 0x11/0x22/0x33, then rx_frame_end with rx_errs=6'b000001 -> frame_avail=1, frame_len=3; three rd_req -> rd_d 0x11,0x22,0x33; rd_last on 0x33; then frame_avail=0.
REQ-034 Two bytes, then rx_frame_end with rx_errs=6'b000100 -> drop pulse, drop_cnt=1, frame_avail=0; next good 1-byte frame 0x5A reads back 0x5A.
REQ-035 AW=6: 65 bytes then good end -> dropped, drop_cnt=1; 64 bytes then good end -> frame_len=64; all 64 bytes read back in order.
REQ-036 Four good 1-byte frames fill the queue (LW=2); a fifth good frame -> drop; after reading one frame, a sixth good frame commits.
REQ-037 q_rdy with q=0xA5 in the same cycle as good rx_frame_end, after one prior byte -> frame_len=2; last byte read is 0xA5.
REQ-038 Assert rst while a frame is half-received and a committed frame is half-read -> all outputs 0; rd_req ignored; a new good frame reads back correctly.
